// File: rtl/adc_cal_pkg.sv
// adc_cal_pkg: shared types and constants for the ADC input-delay calibration block.
package adc_cal_pkg;
   localparam int TAP_W = 4;
   localparam int NTAPS = 16;
   localparam logic [TAP_W-1:0] RST_TAP1 = 4'd2;
   localparam logic [TAP_W-1:0] RST_TAP2 = 4'd0;
   typedef enum logic [2:0] {S_IDLE, S_SET_TAP, S_SETTLE, S_MEASURE, S_EVAL, S_SELECT, S_FINISH} state_t;
   // Simultaneous +1 and -1 cancel; wrap is modulo 16
   function automatic logic [TAP_W-1:0] step_tap(input logic [TAP_W-1:0] t, input logic inc, input logic dec);
      return t + TAP_W'(inc) - TAP_W'(dec);
   endfunction
endpackage

// File: rtl/adc_delay_cal_run_finder.sv
// run_finder: scans a 16-bit pass map one bit per cycle and reports the longest run (lowest start on ties).
module run_finder
   import adc_cal_pkg::*;
(
   input  logic             clkcomm,
   input  logic             RST,
   input  logic             go,
   input  logic [NTAPS-1:0] map,
   output logic [TAP_W-1:0] start,
   output logic [4:0]       len,
   output logic             valid
);
   logic [NTAPS-1:0] r_map;
   logic [TAP_W-1:0] r_idx, r_cur_start, r_best_start;
   logic [4:0]       r_cur_len, r_best_len;
   logic             r_run, r_valid;
   logic [4:0]       w_len;
   logic [TAP_W-1:0] w_start;
   assign w_len   = r_map[r_idx] ? r_cur_len + 5'd1 : 5'd0;
   assign w_start = (r_cur_len == 5'd0) ? r_idx : r_cur_start;
   assign start   = r_best_start;
   assign len     = r_best_len;
   assign valid   = r_valid;
   always_ff @(posedge clkcomm or negedge RST)
      if (!RST) begin
         r_map        <= '0;
         r_idx        <= '0;
         r_cur_start  <= '0;
         r_best_start <= '0;
         r_cur_len    <= '0;
         r_best_len   <= '0;
         r_run        <= 1'b0;
         r_valid      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (go) begin
            r_map        <= map;
            r_idx        <= '0;
            r_cur_len    <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_run        <= 1'b1;
         end else if (r_run) begin
            r_cur_len   <= w_len;
            r_cur_start <= w_start;
            // strict compare keeps the earlier run on ties
            if (w_len > r_best_len) begin
               r_best_len   <= w_len;
               r_best_start <= w_start;
            end
            r_idx <= r_idx + TAP_W'(1);
            if (r_idx == TAP_W'(NTAPS - 1)) begin
               r_run   <= 1'b0;
               r_valid <= 1'b1;
            end
         end
      end
endmodule

// File: rtl/adc_delay_cal.sv
// adc_delay_cal: sweeps each ADC channel's delay tap against a training pattern and centres it in the
// longest passing window; owns both delay registers and applies manual incr/decr pulses while idle.
module adc_delay_cal
   import adc_cal_pkg::*;
#(
   parameter int                DATA_W  = 14,
   parameter logic [DATA_W-1:0] PATTERN = 14'h2A5C,
   parameter int                WIN_LEN = 256,
   parameter int                SETTLE  = 16,
   parameter int                MIN_RUN = 3
) (
   input  logic              clkcomm,
   input  logic              RST,
   input  logic              start,
   input  logic              abort,
   input  logic              ad_valid,
   input  logic [DATA_W-1:0] ad1_data,
   input  logic [DATA_W-1:0] ad2_data,
   input  logic [1:0]        man_incr,
   input  logic [1:0]        man_decr,
   output logic [TAP_W-1:0]  ad1_delay,
   output logic [TAP_W-1:0]  ad2_delay,
   output logic              busy,
   output logic              done,
   output logic [1:0]        fail,
   output logic [NTAPS-1:0]  pass_map1,
   output logic [NTAPS-1:0]  pass_map2
);
   localparam int CNT_W = $clog2((WIN_LEN > SETTLE ? WIN_LEN : SETTLE) + 1);
   state_t           r_state, w_next;
   logic             r_ch2, r_err;
   logic [TAP_W-1:0] r_tap, r_ad1, r_ad2, r_bak1, r_bak2;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_fail;
   logic [NTAPS-1:0] r_map1, r_map2, w_map_eval;
   logic [DATA_W-1:0] w_sample;
   logic             w_go, w_abort, w_rf_valid, w_bad;
   logic [TAP_W-1:0] w_rf_start, w_chosen;
   logic [4:0]       w_rf_len, w_half;
   assign busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign done       = (r_state == S_FINISH);
   assign w_abort    = abort && busy;
   assign w_sample   = r_ch2 ? ad2_data : ad1_data;
   assign w_map_eval = (r_ch2 ? r_map2 : r_map1) | (NTAPS'(!r_err) << r_tap);
   assign w_bad      = w_rf_len < 5'(MIN_RUN);
   assign w_half     = (w_rf_len - 5'd1) >> 1;
   assign w_chosen   = w_rf_start + w_half[TAP_W-1:0];
   assign ad1_delay  = r_ad1;
   assign ad2_delay  = r_ad2;
   assign fail       = r_fail;
   assign pass_map1  = r_map1;
   assign pass_map2  = r_map2;
   run_finder u_rf (
      .clkcomm (clkcomm),
      .RST     (RST),
      .go      (w_go),
      .map     (w_map_eval),
      .start   (w_rf_start),
      .len     (w_rf_len),
      .valid   (w_rf_valid)
   );
   always_ff @(posedge clkcomm or negedge RST)
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_next;
   always_comb begin
      w_next = r_state;
      w_go   = 1'b0;
      if (w_abort) w_next = S_IDLE;
      else
         case (r_state)
            S_IDLE:    w_next = start ? S_SET_TAP : S_IDLE;
            S_SET_TAP: w_next = S_SETTLE;
            S_SETTLE:  w_next = (r_cnt == CNT_W'(SETTLE - 1)) ? S_MEASURE : S_SETTLE;
            S_MEASURE: w_next = (ad_valid && r_cnt == CNT_W'(WIN_LEN - 1)) ? S_EVAL : S_MEASURE;
            S_EVAL: begin
               w_go   = (r_tap == TAP_W'(NTAPS - 1));
               w_next = w_go ? S_SELECT : S_SET_TAP;
            end
            S_SELECT:  w_next = !w_rf_valid ? S_SELECT : (r_ch2 ? S_FINISH : S_SET_TAP);
            default:   w_next = S_IDLE;
         endcase
   end
   always_ff @(posedge clkcomm or negedge RST)
      if (!RST) begin
         r_ad1  <= RST_TAP1;
         r_ad2  <= RST_TAP2;
         r_bak1 <= RST_TAP1;
         r_bak2 <= RST_TAP2;
         r_ch2  <= 1'b0;
         r_err  <= 1'b0;
         r_tap  <= '0;
         r_cnt  <= '0;
         r_fail <= '0;
         r_map1 <= '0;
         r_map2 <= '0;
      end else if (w_abort) begin
         r_ad1 <= r_bak1;
         r_ad2 <= r_bak2;
      end else
         case (r_state)
            S_IDLE:
               if (start) begin
                  r_bak1 <= r_ad1;
                  r_bak2 <= r_ad2;
                  r_fail <= '0;
                  r_map1 <= '0;
                  r_map2 <= '0;
                  r_ch2  <= 1'b0;
                  r_tap  <= '0;
               end else begin
                  r_ad1 <= step_tap(r_ad1, man_incr[0], man_decr[0]);
                  r_ad2 <= step_tap(r_ad2, man_incr[1], man_decr[1]);
               end
            S_SET_TAP: begin
               if (r_ch2) r_ad2 <= r_tap;
               else       r_ad1 <= r_tap;
               r_cnt <= '0;
               r_err <= 1'b0;
            end
            S_SETTLE:  r_cnt <= (r_cnt == CNT_W'(SETTLE - 1)) ? '0 : r_cnt + CNT_W'(1);
            S_MEASURE:
               if (ad_valid) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_sample != PATTERN) r_err <= 1'b1;
               end
            S_EVAL: begin
               if (r_ch2) r_map2 <= w_map_eval;
               else       r_map1 <= w_map_eval;
               r_tap <= r_tap + TAP_W'(1);
            end
            S_SELECT:
               if (w_rf_valid) begin
                  if (r_ch2) r_ad2 <= w_bad ? r_bak2 : w_chosen;
                  else       r_ad1 <= w_bad ? r_bak1 : w_chosen;
                  r_fail <= r_fail | ({r_ch2, !r_ch2} & {2{w_bad}});
                  r_ch2  <= 1'b1;
                  r_tap  <= '0;
               end
            default: ;
         endcase
endmodule

// File: tb/tb_adc_delay_cal.sv
// tb_adc_delay_cal: directed checks of sweep/select, failure restore, ties, manual pulses, abort and async reset.
module tb_adc_delay_cal;
   localparam logic [13:0] PAT = 14'h2A5C;
   logic        clkcomm, RST, start, abort, ad_valid;
   logic [13:0] ad1_data, ad2_data;
   logic [1:0]  man_incr, man_decr, fail;
   logic [3:0]  ad1_delay, ad2_delay;
   logic        busy, done;
   logic [15:0] pass_map1, pass_map2, m1, m2;
   int          total = 0, bad = 0, n_done = 0;
   adc_delay_cal #(.DATA_W(14), .PATTERN(PAT), .WIN_LEN(4), .SETTLE(2), .MIN_RUN(3)) dut (
      .clkcomm   (clkcomm),
      .RST       (RST),
      .start     (start),
      .abort     (abort),
      .ad_valid  (ad_valid),
      .ad1_data  (ad1_data),
      .ad2_data  (ad2_data),
      .man_incr  (man_incr),
      .man_decr  (man_decr),
      .ad1_delay (ad1_delay),
      .ad2_delay (ad2_delay),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .pass_map1 (pass_map1),
      .pass_map2 (pass_map2)
   );
   // channel model: a tap passes when its bit is set in m1/m2
   assign ad1_data = m1[ad1_delay] ? PAT : ~PAT;
   assign ad2_data = m2[ad2_delay] ? PAT : ~PAT;
   initial clkcomm = 1'b0;
   always #5 clkcomm = ~clkcomm;
   always @(negedge clkcomm) if (done) n_done++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic run_cal(input string tag);
      int n, d0;
      d0 = n_done;
      start = 1'b1;
      @(negedge clkcomm);
      start = 1'b0;
      n = 1;
      while (!done && n < 2000) begin
         @(negedge clkcomm);
         n++;
      end
      chk({tag, "_cycles"}, n, 291);
      repeat (2) @(negedge clkcomm);
      chk({tag, "_ndone"}, n_done - d0, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      int d0;
      RST = 1'b0; start = 1'b0; abort = 1'b0; ad_valid = 1'b1;
      man_incr = 2'b00; man_decr = 2'b00; m1 = '0; m2 = '0;
      repeat (3) @(negedge clkcomm);
      chk("rst_ad1", ad1_delay, 2);
      chk("rst_ad2", ad2_delay, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_maps", {pass_map1, pass_map2}, 0);
      RST = 1'b1;
      @(negedge clkcomm);
      m1 = 16'h0FE0; m2 = 16'h000F;
      run_cal("cal1");
      chk("cal1_map1", pass_map1, 16'h0FE0);
      chk("cal1_ad1", ad1_delay, 8);
      chk("cal1_map2", pass_map2, 16'h000F);
      chk("cal1_ad2", ad2_delay, 1);
      chk("cal1_fail", fail, 0);
      m1 = 16'h1E1E;
      run_cal("tie");
      chk("tie_map1", pass_map1, 16'h1E1E);
      chk("tie_ad1", ad1_delay, 2);
      chk("tie_ad2", ad2_delay, 1);
      chk("tie_fail", fail, 0);
      RST = 1'b0;
      @(negedge clkcomm);
      RST = 1'b1;
      @(negedge clkcomm);
      m1 = 16'h000C; m2 = 16'h0000;
      run_cal("fail");
      chk("fail_flags", fail, 2'b11);
      chk("fail_ad1", ad1_delay, 2);
      chk("fail_ad2", ad2_delay, 0);
      chk("fail_map1", pass_map1, 16'h000C);
      chk("fail_map2", pass_map2, 16'h0000);
      man_decr = 2'b01;
      repeat (3) @(negedge clkcomm);
      man_decr = 2'b00;
      chk("man_dec_wrap1", ad1_delay, 15);
      man_incr = 2'b01;
      @(negedge clkcomm);
      man_incr = 2'b00;
      chk("man_inc_wrap", ad1_delay, 0);
      man_decr = 2'b10;
      @(negedge clkcomm);
      man_decr = 2'b00;
      chk("man_dec_wrap2", ad2_delay, 15);
      man_incr = 2'b01; man_decr = 2'b01;
      @(negedge clkcomm);
      man_incr = 2'b00; man_decr = 2'b00;
      chk("man_both", ad1_delay, 0);
      m1 = 16'h0FE0; m2 = 16'h000F;
      start = 1'b1;
      @(negedge clkcomm);
      start = 1'b0;
      repeat (150) @(negedge clkcomm);
      chk("ab_ch1_sel", ad1_delay, 8);
      chk("ab_busy", busy, 1);
      start = 1'b1; man_incr = 2'b11;
      @(negedge clkcomm);
      start = 1'b0; man_incr = 2'b00;
      repeat (20) @(negedge clkcomm);
      chk("ab_start_ign", ad1_delay, 8);
      chk("ab_busy2", busy, 1);
      d0 = n_done;
      abort = 1'b1;
      @(negedge clkcomm);
      abort = 1'b0;
      chk("ab_ad1", ad1_delay, 0);
      chk("ab_ad2", ad2_delay, 15);
      chk("ab_idle", busy, 0);
      chk("ab_map1", pass_map1, 16'h0FE0);
      repeat (400) @(negedge clkcomm);
      chk("ab_no_done", n_done - d0, 0);
      chk("ab_hold", {ad1_delay, ad2_delay}, 8'h0F);
      start = 1'b1;
      @(negedge clkcomm);
      start = 1'b0;
      repeat (5) @(negedge clkcomm);
      #2 RST = 1'b0;
      #1;
      chk("ar_ad1", ad1_delay, 2);
      chk("ar_ad2", ad2_delay, 0);
      chk("ar_busy", busy, 0);
      chk("ar_map1", pass_map1, 0);
      @(negedge clkcomm);
      RST = 1'b1;
      @(negedge clkcomm);
      run_cal("post");
      chk("post_ad1", ad1_delay, 8);
      chk("post_ad2", ad2_delay, 1);
      chk("post_fail", fail, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
